seg_595_capture: RTL

SEG_595_CAPTURE -- requirements
Module: seg_595_capture

---
 rtl/seg_595_capture.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_595_capture.sv
// Snoops a 74HC595 seven-segment driver bus (ds/shcp/stcp/oe) and
// rebuilds the latched segment/select words and the six displayed digits.
module seg_595_capture #(
    parameter int WORD_BITS   = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ds,
    input  logic        shcp,
    input  logic        stcp,
    input  logic        oe,
    output logic [7:0]  seg_word,
    output logic [5:0]  sel_word,
    output logic        word_valid,
    output logic        frame_err,
    output logic [23:0] digits,
    output logic [5:0]  points,
    output logic        frame_done,
    output logic        dec_err
);

    localparam int CW = $clog2(WORD_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_BITS + 1);

    logic [SYNC_STAGES-1:0] ds_q;
    logic [SYNC_STAGES-1:0] shcp_q;
    logic [SYNC_STAGES-1:0] stcp_q;
    logic [SYNC_STAGES-1:0] oe_q;
    logic                   shcp_d;
    logic                   stcp_d;

    logic                   ds_s;
    logic                   shcp_s;
    logic                   stcp_s;
    logic                   oe_s;
    logic                   shift_rise;
    logic                   latch_rise;

    logic [WORD_BITS-1:0]   sr;
    logic [WORD_BITS-1:0]   sr_eff;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_eff;
    logic                   good_word;
    logic                   bad_word;

    logic                   upd;
    logic [5:0]             seen;
    logic [5:0]             seen_base;
    logic [5:0]             sel_m1;
    logic                   one_hot;
    logic [3:0]             code;

    assign ds_s   = ds_q[SYNC_STAGES-1];
    assign shcp_s = shcp_q[SYNC_STAGES-1];
    assign stcp_s = stcp_q[SYNC_STAGES-1];
    assign oe_s   = oe_q[SYNC_STAGES-1];

    assign shift_rise = shcp_s & ~shcp_d;
    assign latch_rise = stcp_s & ~stcp_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ds_q   <= '0;
            shcp_q <= '0;
            stcp_q <= '0;
            oe_q   <= '0;
            shcp_d <= 1'b0;
            stcp_d <= 1'b0;
        end else begin
            ds_q[0]   <= ds;
            shcp_q[0] <= shcp;
            stcp_q[0] <= stcp;
            oe_q[0]   <= oe;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ds_q[i]   <= ds_q[i-1];
                shcp_q[i] <= shcp_q[i-1];
                stcp_q[i] <= stcp_q[i-1];
                oe_q[i]   <= oe_q[i-1];
            end
            shcp_d <= shcp_s;
            stcp_d <= stcp_s;
        end
    end

    // A shift landing in the same cycle as the latch is folded in first.
    always_comb begin
        sr_eff  = sr;
        cnt_eff = cnt;
        if (shift_rise) begin
            sr_eff  = {sr[WORD_BITS-2:0], ds_s};
            cnt_eff = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        end
    end

    assign good_word = latch_rise & ~oe_s & (cnt_eff == CNT_FULL);
    assign bad_word  = latch_rise & ~oe_s & (cnt_eff != CNT_FULL);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            upd       <= 1'b0;
            frame_err <= 1'b0;
            seg_word  <= 8'hFF;
            sel_word  <= 6'd0;
        end else begin
            sr        <= sr_eff;
            cnt       <= latch_rise ? '0 : cnt_eff;
            upd       <= good_word;
            frame_err <= bad_word;
            if (good_word) begin
                seg_word <= sr_eff[13:6];
                sel_word <= sr_eff[5:0];
            end
        end
    end

    always_comb begin
        code = 4'hE;
        case (seg_word[6:0])
            7'h40:   code = 4'h0;
            7'h79:   code = 4'h1;
            7'h24:   code = 4'h2;
            7'h30:   code = 4'h3;
            7'h19:   code = 4'h4;
            7'h12:   code = 4'h5;
            7'h02:   code = 4'h6;
            7'h78:   code = 4'h7;
            7'h00:   code = 4'h8;
            7'h10:   code = 4'h9;
            7'h7F:   code = 4'hF;
            7'h3F:   code = 4'hA;
            default: code = 4'hE;
        endcase
    end

    assign sel_m1    = sel_word - 6'd1;
    assign one_hot   = (sel_word != 6'd0) && ((sel_word & sel_m1) == 6'd0);
    assign seen_base = (seen == 6'h3F) ? 6'd0 : seen;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            dec_err    <= 1'b0;
            seen       <= 6'd0;
            digits     <= 24'hFFFFFF;
            points     <= 6'd0;
        end else begin
            word_valid <= upd;
            frame_done <= (seen == 6'h3F);
            seen       <= (upd && one_hot) ? (seen_base | sel_word) : seen_base;
            if (upd) begin
                if (one_hot) begin
                    for (int i = 0; i < 6; i++) begin
                        if (sel_word[i]) begin
                            digits[4*i +: 4] <= code;
                            points[i]        <= ~seg_word[7];
                        end
                    end
                    if (code == 4'hE) dec_err <= 1'b1;
                end else begin
                    dec_err <= 1'b1;
                end
            end
        end
    end

endmodule
